// File: rtl/name_stride_sched.sv
// Round-robin name scheduler: grants one lane per whole name, cuts the name
// into strides on '/' or when a stride fills, and truncates overlong names.
module name_stride_sched #(
  parameter int CHAR_SIZE   = 8,
  parameter int STRIDE_SIZE = 8,
  parameter int MAX_STRIDES = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [1:0]                           in_valid,
  input  logic [2*CHAR_SIZE-1:0]               in_char,
  input  logic [1:0]                           in_last,
  output logic [1:0]                           in_ready,
  output logic                                 stride_valid,
  input  logic                                 stride_ready,
  output logic [STRIDE_SIZE*CHAR_SIZE-1:0]     stride_data,
  output logic [$clog2(STRIDE_SIZE+1)-1:0]     stride_len,
  output logic [$clog2(MAX_STRIDES)-1:0]       stride_idx,
  output logic                                 stride_lane,
  output logic                                 stride_last,
  output logic                                 stride_trunc
);
  localparam int LEN_W = $clog2(STRIDE_SIZE + 1);
  localparam int CNT_W = $clog2(MAX_STRIDES);
  localparam int POS_W = $clog2(STRIDE_SIZE);
  localparam logic [CHAR_SIZE-1:0] SLASH = CHAR_SIZE'(8'h2F);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT, DRAIN} state_t;

  state_t               state, state_nx;
  logic                 rr_ptr;
  logic                 lane;
  logic                 grant;
  logic [LEN_W-1:0]     acc_len;
  logic [CNT_W-1:0]     cnt;
  logic                 last_q;
  logic                 trunc_q;
  logic [CHAR_SIZE-1:0] acc [STRIDE_SIZE];

  logic                 cur_valid;
  logic                 cur_last;
  logic [CHAR_SIZE-1:0] cur_char;
  logic                 close;
  logic                 accept;
  logic                 at_max;
  logic [POS_W-1:0]     wr_pos;

  assign grant     = in_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
  assign cur_valid = in_valid[lane];
  assign cur_last  = in_last[lane];
  assign cur_char  = lane ? in_char[2*CHAR_SIZE-1:CHAR_SIZE] : in_char[CHAR_SIZE-1:0];
  assign wr_pos    = acc_len[POS_W-1:0];
  assign at_max    = (cnt == CNT_W'(MAX_STRIDES - 1));

  // The closing character is left on the lane; it opens the next stride.
  assign close = cur_valid && (acc_len != '0) &&
                 ((acc_len == LEN_W'(STRIDE_SIZE)) || (cur_char == SLASH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    in_ready     = 2'b00;
    accept       = 1'b0;
    stride_valid = 1'b0;
    case (state)
      IDLE: begin
        if (|in_valid) state_nx = COLLECT;
      end
      COLLECT: begin
        in_ready[lane] = !close;
        accept         = cur_valid && !close;
        if ((accept && cur_last) || close) state_nx = EMIT;
      end
      EMIT: begin
        stride_valid = 1'b1;
        if (stride_ready) begin
          if (trunc_q)     state_nx = DRAIN;
          else if (last_q) state_nx = IDLE;
          else             state_nx = COLLECT;
        end
      end
      DRAIN: begin
        in_ready[lane] = 1'b1;
        if (cur_valid && cur_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= 1'b0;
      lane    <= 1'b0;
      acc_len <= '0;
      cnt     <= '0;
      last_q  <= 1'b0;
      trunc_q <= 1'b0;
      for (int k = 0; k < STRIDE_SIZE; k++) acc[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|in_valid) begin
            lane   <= grant;
            rr_ptr <= ~grant;
          end
        end
        COLLECT: begin
          if (accept) begin
            acc[wr_pos] <= cur_char;
            acc_len     <= acc_len + 1'b1;
            if (cur_last) begin
              last_q  <= 1'b1;
              trunc_q <= 1'b0;
            end
          end else if (close) begin
            // Closing the final permitted stride ends the name early.
            last_q  <= at_max;
            trunc_q <= at_max;
          end
        end
        EMIT: begin
          if (stride_ready) begin
            for (int k = 0; k < STRIDE_SIZE; k++) acc[k] <= '0;
            acc_len <= '0;
            last_q  <= 1'b0;
            trunc_q <= 1'b0;
            if (!last_q)       cnt <= cnt + 1'b1;
            else if (!trunc_q) cnt <= '0;
          end
        end
        DRAIN: begin
          if (cur_valid && cur_last) cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < STRIDE_SIZE; k++) begin : g_flat
    assign stride_data[k*CHAR_SIZE +: CHAR_SIZE] = acc[k];
  end

  assign stride_len   = acc_len;
  assign stride_idx   = cnt;
  assign stride_lane  = lane;
  assign stride_last  = last_q;
  assign stride_trunc = trunc_q;
endmodule

// File: tb/tb_name_stride_sched.sv
// Scoreboard bench for name_stride_sched: names are split into expected strides
// by a reference model, and a monitor checks each stride handshake in order.
module tb_name_stride_sched;
  logic        clk;
  logic        rst_n;
  logic [1:0]  in_valid;
  logic [15:0] in_char;
  logic [1:0]  in_last;
  logic [1:0]  in_ready;
  logic        stride_valid;
  logic        stride_ready;
  logic [63:0] stride_data;
  logic [3:0]  stride_len;
  logic [1:0]  stride_idx;
  logic        stride_lane;
  logic        stride_last;
  logic        stride_trunc;

  name_stride_sched #(.CHAR_SIZE(8), .STRIDE_SIZE(8), .MAX_STRIDES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_char(in_char), .in_last(in_last), .in_ready(in_ready),
    .stride_valid(stride_valid), .stride_ready(stride_ready),
    .stride_data(stride_data), .stride_len(stride_len), .stride_idx(stride_idx),
    .stride_lane(stride_lane), .stride_last(stride_last), .stride_trunc(stride_trunc)
  );

  typedef struct {
    logic [63:0] data;
    logic [3:0]  len;
    logic [1:0]  idx;
    logic        lane;
    logic        last;
    logic        trunc;
  } exp_t;

  exp_t       expq[$];
  exp_t       mon_e;
  logic [8:0] lq0[$];
  logic [8:0] lq1[$];
  logic [7:0] nm[$];
  logic [1:0] first;
  logic       m_rr;
  logic       gaps;
  int         sr_mode;
  int         nacc;
  int         blk0;
  logic       started0;
  int         errors;
  int         checks;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_nm(input string s);
    nm.delete();
    for (int i = 0; i < s.len(); i++) nm.push_back(s[i]);
  endtask

  task automatic gen_rand();
    int n;
    n = $urandom_range(1, 34);
    nm.delete();
    for (int i = 0; i < n; i++)
      nm.push_back(($urandom_range(0, 4) == 0) ? 8'h2F : 8'(8'h61 + $urandom_range(0, 25)));
  endtask

  // Reference model: cut nm into strides and queue its characters on lane ln.
  task automatic add_name(input logic ln);
    exp_t e;
    int   cnt;
    int   len;
    logic done;
    cnt = 0; len = 0; done = 1'b0; e.data = '0;
    for (int i = 0; i < nm.size(); i++) begin
      if (ln) lq1.push_back({(i == nm.size() - 1), nm[i]});
      else    lq0.push_back({(i == nm.size() - 1), nm[i]});
    end
    for (int i = 0; i < nm.size(); i++) begin
      if (!done) begin
        if (len > 0 && (len == 8 || nm[i] == "/")) begin
          e.len = len[3:0]; e.idx = cnt[1:0]; e.lane = ln;
          e.last = (cnt == 3); e.trunc = (cnt == 3);
          expq.push_back(e);
          if (cnt == 3) done = 1'b1;
          cnt++; len = 0; e.data = '0;
        end
        if (!done) begin
          e.data[len*8 +: 8] = nm[i];
          len++;
        end
      end
    end
    if (!done) begin
      e.len = len[3:0]; e.idx = cnt[1:0]; e.lane = ln; e.last = 1'b1; e.trunc = 1'b0;
      expq.push_back(e);
    end
    m_rr = ~ln;
  endtask

  // Name-level round robin over lanes that still have names queued.
  task automatic rand_batch(input int r0, input int r1);
    logic ln;
    while (r0 > 0 || r1 > 0) begin
      if (m_rr == 1'b0) ln = (r0 > 0) ? 1'b0 : 1'b1;
      else              ln = (r1 > 0) ? 1'b1 : 1'b0;
      gen_rand();
      add_name(ln);
      if (ln) r1--; else r0--;
    end
  endtask

  task automatic wait_done(input int lim, input string tag);
    int t;
    t = 0;
    while ((lq0.size() > 0 || lq1.size() > 0 || expq.size() > 0) && t < lim) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= lim) begin
      errors++;
      $display("FAIL %s: timeout with %0d strides outstanding, required 0", tag, expq.size());
      lq0.delete(); lq1.delete(); expq.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    logic [75:0] outs;
    outs = {stride_valid, stride_data, stride_len, stride_idx, stride_lane,
            stride_last, stride_trunc, in_ready};
    checks++;
    if (outs != '0) begin
      errors++;
      $display("FAIL %s: outputs=%h, required all zero", tag, outs);
    end
  endtask

  // Driver: present queue heads each cycle, pop on acceptance before the edge.
  initial begin
    logic [1:0]  dv;
    logic [15:0] dc;
    logic [1:0]  dl;
    in_valid = '0; in_char = '0; in_last = '0; stride_ready = 1'b0;
    forever begin
      @(negedge clk);
      dv = '0; dc = '0; dl = '0;
      if (lq0.size() > 0 && (first[0] || !gaps || $urandom_range(0, 3) != 0)) begin
        dv[0] = 1'b1; dc[7:0] = lq0[0][7:0]; dl[0] = lq0[0][8];
      end
      if (lq1.size() > 0 && (first[1] || !gaps || $urandom_range(0, 3) != 0)) begin
        dv[1] = 1'b1; dc[15:8] = lq1[0][7:0]; dl[1] = lq1[0][8];
      end
      in_valid = dv; in_char = dc; in_last = dl;
      case (sr_mode)
        0:       stride_ready = 1'b1;
        1:       stride_ready = ($urandom_range(0, 2) != 0);
        default: stride_ready = 1'b0;
      endcase
      #4;
      if (rst_n && in_valid[0] && in_ready[0] && lq0.size() > 0) begin
        first[0] = lq0[0][8];
        void'(lq0.pop_front());
        nacc++;
        started0 = 1'b1;
      end
      if (rst_n && in_valid[1] && in_ready[1] && lq1.size() > 0) begin
        first[1] = lq1[0][8];
        void'(lq1.pop_front());
      end
    end
  end

  // Monitor: pop the scoreboard on every stride handshake.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      checks++;
      if (!$onehot0(in_ready)) begin
        errors++;
        $display("FAIL in_ready_onehot: got %b, required at most one bit high", in_ready);
      end
      if (started0 && in_valid[0] && !in_ready[0] && !stride_valid) blk0++;
      if (stride_valid && stride_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL stride_unexpected: got lane%0d idx%0d len%0d data=%h, required no stride",
                   stride_lane, stride_idx, stride_len, stride_data);
        end else begin
          mon_e = expq.pop_front();
          if (stride_data !== mon_e.data || stride_len !== mon_e.len || stride_idx !== mon_e.idx ||
              stride_lane !== mon_e.lane || stride_last !== mon_e.last || stride_trunc !== mon_e.trunc) begin
            errors++;
            $display("FAIL stride: got data=%h len=%0d idx=%0d lane=%0d last=%0d trunc=%0d, required data=%h len=%0d idx=%0d lane=%0d last=%0d trunc=%0d",
                     stride_data, stride_len, stride_idx, stride_lane, stride_last, stride_trunc,
                     mon_e.data, mon_e.len, mon_e.idx, mon_e.lane, mon_e.last, mon_e.trunc);
          end
        end
      end
    end
  end

  initial begin
    logic [72:0] snap;
    logic        ln;
    int          i0, i1, t;
    errors = 0; checks = 0; nacc = 0; blk0 = 0; started0 = 1'b0;
    first = 2'b11; m_rr = 1'b0; gaps = 1'b0; sr_mode = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 chk_zero("reset_outputs");
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #3 chk_zero("idle_after_reset");

    // Two two-stride names per lane, both lanes competing.
    i0 = 0; i1 = 0;
    for (int s = 0; s < 4; s++) begin
      if (m_rr == 1'b0) ln = (i0 < 2) ? 1'b0 : 1'b1;
      else              ln = (i1 < 2) ? 1'b1 : 1'b0;
      if (ln) begin set_nm(i1 == 0 ? "/ij/kl" : "/mn/op"); i1++; end
      else    begin set_nm(i0 == 0 ? "/ab/cd" : "/ef/gh"); i0++; end
      add_name(ln);
    end
    wait_done(400, "pair_rr");

    blk0 = 0; started0 = 1'b0;
    set_nm("/ab/cd"); add_name(1'b0);
    wait_done(200, "slash_split");
    checks++;
    if (blk0 != 1) begin
      errors++;
      $display("FAIL close_block_cycles: got %0d, required 1", blk0);
    end

    set_nm("/abcdefghij"); add_name(1'b1);
    wait_done(200, "full_stride");

    set_nm("/a/b/c/d/e/f"); add_name(1'b0);
    set_nm("xy"); add_name(1'b0);
    wait_done(300, "truncate");

    // Backpressure: outputs must hold while stride_ready is low.
    sr_mode = 2;
    set_nm("/ab/cd"); add_name(1'b0);
    t = 0;
    while (!stride_valid && t < 50) begin
      @(negedge clk); #3; t++;
    end
    checks++;
    if (!stride_valid) begin
      errors++;
      $display("FAIL stall_wait: stride_valid=%0d, required 1", stride_valid);
    end
    snap = {stride_data, stride_len, stride_idx, stride_lane, stride_last, stride_trunc};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #3;
      checks++;
      if (!stride_valid || in_ready != 2'b00 ||
          snap != {stride_data, stride_len, stride_idx, stride_lane, stride_last, stride_trunc}) begin
        errors++;
        $display("FAIL stall_hold: valid=%0d in_ready=%b outs=%h, required valid=1 in_ready=00 outs=%h",
                 stride_valid, in_ready,
                 {stride_data, stride_len, stride_idx, stride_lane, stride_last, stride_trunc}, snap);
      end
    end
    sr_mode = 0;
    wait_done(200, "stall_release");

    // Reset in the middle of a name with three characters accumulated.
    nacc = 0;
    set_nm("/abcdefg"); add_name(1'b0);
    t = 0;
    while (nacc < 3 && t < 50) begin
      @(negedge clk); t++;
    end
    #1 rst_n = 1'b0;
    #1 chk_zero("async_reset_mid_name");
    lq0.delete(); lq1.delete(); expq.delete();
    first = 2'b11; m_rr = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk_zero("held_reset");
    rst_n = 1'b1;
    set_nm("/xy/z"); add_name(1'b0);
    set_nm("k"); add_name(1'b1);
    wait_done(200, "after_reset");

    // Randomized names, random input gaps and random backpressure.
    gaps = 1'b1; sr_mode = 1;
    for (int b = 0; b < 8; b++) begin
      rand_batch($urandom_range(0, 4), $urandom_range(0, 4));
      wait_done(4000, "random_batch");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/name_stride_sched.md
Name: name_stride_sched

Overview:
- Front-end scheduler for the dual-issue name path.
- Arbitrates two lane character streams round-robin at whole-name granularity.
- Segments the granted name into strides (new stride on '/' or after STRIDE_SIZE chars) and hands each stride to the lookup datapath over a valid/ready port.
- Owns truncation of names exceeding MAX_STRIDES.

Parameters:
- CHAR_SIZE, 8, bits per character
- STRIDE_SIZE, 8, max characters per stride
- MAX_STRIDES, 4, max strides per name (WORD_SIZE/STRIDE_SIZE)

Ports:
- clk  in  1  clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  2  per-lane character valid
- in_char  in  2*CHAR_SIZE  per-lane character; lane i at [i*CHAR_SIZE +: CHAR_SIZE]
- in_last  in  2  per-lane last character of name
- in_ready  out  2  per-lane accept; at most one bit high
- stride_valid  out  1  stride available
- stride_ready  in  1  downstream accepts stride
- stride_data  out  STRIDE_SIZE*CHAR_SIZE  char k at [k*CHAR_SIZE +: CHAR_SIZE]; unused bytes 8'h00
- stride_len  out  $clog2(STRIDE_SIZE+1)  valid chars, 1..STRIDE_SIZE
- stride_idx  out  $clog2(MAX_STRIDES)  stride number within name, from 0
- stride_lane  out  1  source lane
- stride_last  out  1  final stride of name
- stride_trunc  out  1  name was truncated (valid with stride_last)

Behaviour:
- Reset (async assert, sync release): state IDLE, rr_ptr=0, accumulator all 8'h00, acc_len=0, stride count=0; all outputs 0.
- FSM states: IDLE, COLLECT, EMIT, DRAIN.
- IDLE:
  - If any in_valid, grant = rr_ptr lane if valid, else the other valid lane; go to COLLECT next cycle. in_ready=0 in IDLE.
  - rr_ptr <= ~grant on grant.
- COLLECT, granted lane g only:
  - close = in_valid[g] && acc_len>0 && (acc_len==STRIDE_SIZE || in_char[g]=="/").
  - in_ready[g] = !close (combinational from in_valid/in_char). The closing char is NOT consumed; it starts the next stride after EMIT.
  - On accept: write char at acc_len, acc_len++.
  - If the accepted char has in_last=1: go to EMIT with last=1.
  - If close: go to EMIT with last=0. Exception: if stride count==MAX_STRIDES-1, go to EMIT with last=1, trunc=1.
- EMIT:
  - stride_valid=1; data/len/idx/lane/last/trunc held stable until stride_ready.
  - On handshake: clear accumulator to 8'h00 and acc_len=0.
    - last=0: stride count++, go to COLLECT.
    - last=1, trunc=0: stride count=0, go to IDLE.
    - trunc=1: go to DRAIN.
- DRAIN: in_ready[g]=1; discard chars until in_last accepted; then stride count=0, go to IDLE.
- Latency:
  - First char accepted 1 cycle after IDLE sees in_valid.
  - stride_valid rises 1 cycle after the closing condition or last-char accept.
  - 1 char/cycle in COLLECT; no stride emitted with len 0.
- Lane 1-g may hold in_valid during a name; it is never accepted and waits.
- Single-char name with in_last: one stride, len=1, idx=0, last=1.
- A '/' with acc_len==0 (name start) is accepted normally.
- rst_n low mid-name: immediate return to reset values; partial stride discarded, never emitted.

Test Plan:
- Lane0 "/ab/cd" last on 'd', stride_ready=1 -> strides {"/ab",len3,idx0,last0}, {"/cd",len3,idx1,last1,trunc0}, lane0; in_ready[0] low exactly one cycle at the second '/'.
- Lane1 "/abcdefghij" (11 chars) -> {"/abcdefg",len8,idx0,last0}, {"hij",len3,idx1,last1}; bytes 3..7 of the second stride = 00.
- Both lanes valid from reset, two-stride names each -> order lane0, lane1, lane0, lane1; strides of different names never interleave.
- Lane0 "/a/b/c/d/e/f" last on 'f' -> 4 strides, idx3 = "/d" with last=1, trunc=1; "/e/f" drained with in_ready high; next name starts idx0.
- stride_ready held 0 for 5 cycles in EMIT -> all stride outputs stable; in_ready=00; resumes on release.
- rst_n pulsed low while 3 chars are accumulated -> outputs 0 asynchronously; no stride emitted; the next name after release starts idx0 on lane0.
